// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control FSM and
// the ALU operation decoder (states, opcode values, instruction classes,
// ALU op codes, PC/writeback mux selects).
package ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT_W    = 10;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned F7_W       = 7;
  localparam int unsigned ALU_CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_IALU    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_BNE     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_e;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd9;

  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_BRANCH = 1'b1;
  localparam logic WB_ALU    = 1'b0;
  localparam logic WB_MDR    = 1'b1;

  // Opcode (plus funct3 for branches) to instruction class.
  function automatic cls_e classify(input logic [OPCODE_W-1:0] opcode,
                                    input logic [F3_W-1:0]     funct3);
    cls_e cls;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ)      cls = CLS_BEQ;
        else if (funct3 == F3_BNE) cls = CLS_BNE;
        else                       cls = CLS_ILLEGAL;
      end
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Base ALU op selected by funct3 alone (funct7 modifiers applied by caller).
  function automatic logic [ALU_CODE_W-1:0] base_op(input logic [F3_W-1:0] funct3);
    logic [ALU_CODE_W-1:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational {class, funct7/funct3} -> {alu_op, illegal}.
// Shared between the multi-cycle control and future pipelined control.
// Ports:
//   cls          in   instruction class
//   ins_for_alu  in   {funct7, funct3}
//   alu_op       out  ALU operation code (ALU_OP_W bits)
//   illegal      out  encoding not supported for this class
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4
) (
  input  cls_e                cls,
  input  logic [FUNCT_W-1:0]  ins_for_alu,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  logic [F7_W-1:0]       funct7;
  logic [F3_W-1:0]       funct3;
  logic [ALU_CODE_W-1:0] op_c;

  assign funct7 = ins_for_alu[FUNCT_W-1:F3_W];
  assign funct3 = ins_for_alu[F3_W-1:0];

  // Class-specific op selection and funct7 legality.
  always_comb begin
    op_c    = ALU_ADD;
    illegal = 1'b0;
    case (cls)
      CLS_R: begin
        if (funct7 == F7_BASE)                       op_c = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) op_c = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) op_c = ALU_SRA;
        else                                         illegal = 1'b1;
      end
      CLS_IALU: begin
        // f3=000 is ADDI regardless of funct7 (immediate bits, not a modifier).
        op_c = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       op_c = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      CLS_LOAD, CLS_STORE: op_c = ALU_ADD;
      CLS_BEQ, CLS_BNE:    op_c = ALU_SUB;
      default:             illegal = 1'b1;
    endcase
  end

  assign alu_op = ALU_OP_W'(op_c);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and the
// shared instruction/data memory handshakes. Outputs are combinational from
// state, latched instruction class and acks; IDLE drives all outputs 0.
// Build option: CTRL_ILLEGAL_TRAP_EN -- illegal instructions halt in TRAP
// (trap=1 until reset); otherwise they retire as a NOP from DECODE.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   run               enable sequencing (sampled at instruction boundaries)
//   opcode            decoder opcode field
//   ins_for_ALU       decoder {funct7, funct3}
//   alu_zero          ALU result==0 (valid in EXEC)
//   imem_ack/dmem_ack memory handshake completions
//   imem_req/dmem_req/dmem_we            memory requests
//   ir_we/ab_we/alu_out_we/mdr_we/reg_we datapath register loads
//   wb_sel/alu_src_imm/alu_op            datapath muxes / ALU op
//   pc_we/pc_sel                         PC update
//   instr_retired/trap                   status
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned IMEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  ins_for_ALU,
  input  logic                alu_zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                ab_we,
  output logic                alu_out_we,
  output logic                mdr_we,
  output logic                reg_we,
  output logic                wb_sel,
  output logic                alu_src_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                instr_retired,
  output logic                trap
);

  // IMEM_TIMEOUT is reserved and must be 0.
  if (IMEM_TIMEOUT != 0) begin : g_timeout_unsupported
    $error("multicycle_ctrl: IMEM_TIMEOUT must be 0");
  end

  state_e state_q, state_d;
  cls_e   cls_q, cls_c, dec_cls;
  state_e fetch_or_idle;

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_illegal;
  logic                branch_taken;

  assign cls_c = classify(opcode, ins_for_ALU[F3_W-1:0]);

  // DECODE judges legality on the live fields; EXEC uses the latched class.
  assign dec_cls = (state_q == DECODE) ? cls_c : cls_q;

  alu_op_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_op_decode (
    .cls         (dec_cls),
    .ins_for_alu (ins_for_ALU),
    .alu_op      (dec_alu_op),
    .illegal     (dec_illegal)
  );

  assign fetch_or_idle = run ? FETCH : IDLE;
  assign branch_taken  = ((cls_q == CLS_BEQ) & alu_zero) |
                         ((cls_q == CLS_BNE) & ~alu_zero);

  // State and instruction-class registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) cls_q <= cls_c;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    ab_we         = 1'b0;
    alu_out_we    = 1'b0;
    mdr_we        = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    alu_src_imm   = 1'b0;
    alu_op        = '0;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    instr_retired = 1'b0;
    trap          = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        ab_we = 1'b1;
        if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          pc_we         = 1'b1;
          pc_sel        = PC_PLUS4;
          instr_retired = 1'b1;
          state_d       = fetch_or_idle;
`endif
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_out_we  = 1'b1;
        alu_op      = dec_alu_op;
        alu_src_imm = (cls_q == CLS_IALU) || (cls_q == CLS_LOAD) ||
                      (cls_q == CLS_STORE);
        case (cls_q)
          CLS_BEQ, CLS_BNE: begin
            pc_we         = 1'b1;
            pc_sel        = branch_taken ? PC_BRANCH : PC_PLUS4;
            instr_retired = 1'b1;
            state_d       = fetch_or_idle;
          end
          CLS_LOAD, CLS_STORE: state_d = MEM;
          default:             state_d = WB;
        endcase
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_we         = 1'b1;
            pc_sel        = PC_PLUS4;
            instr_retired = 1'b1;
            state_d       = fetch_or_idle;
          end else begin
            mdr_we  = 1'b1;
            state_d = WB;
          end
        end
      end

      WB: begin
        reg_we        = 1'b1;
        wb_sel        = (cls_q == CLS_LOAD) ? WB_MDR : WB_ALU;
        pc_we         = 1'b1;
        pc_sel        = PC_PLUS4;
        instr_retired = 1'b1;
        state_d       = fetch_or_idle;
      end

      TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap    = 1'b1;
        state_d = TRAP;
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues directed and random
// instructions with random memory latencies, a reference model pushes the
// expected retirement record, and a monitor compares on each instr_retired.
module tb_multicycle_ctrl;

  localparam int unsigned ALU_OP_W = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n, run, alu_zero, imem_ack, dmem_ack;
  logic [6:0]          opcode;
  logic [9:0]          ins_for_ALU;
  logic                imem_req, dmem_req, dmem_we, ir_we, ab_we, alu_out_we;
  logic                mdr_we, reg_we, wb_sel, alu_src_imm, pc_we, pc_sel;
  logic                instr_retired, trap;
  logic [ALU_OP_W-1:0] alu_op;
  logic [17:0]         all_outs;

  multicycle_ctrl #(.ALU_OP_W(ALU_OP_W), .IMEM_TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .ins_for_ALU(ins_for_ALU), .alu_zero(alu_zero), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .ab_we(ab_we), .alu_out_we(alu_out_we),
    .mdr_we(mdr_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .pc_we(pc_we),
    .pc_sel(pc_sel), .instr_retired(instr_retired), .trap(trap)
  );

  always #5 clk = ~clk;

  // trap is bit 0 so a trapped core reads as 18'd1.
  assign all_outs = {imem_req, dmem_req, dmem_we, ir_we, ab_we, alu_out_we,
                     mdr_we, reg_we, wb_sel, alu_src_imm, pc_we, pc_sel,
                     instr_retired, alu_op, trap};

  typedef struct {
    int         lat;
    bit         exec;
    logic [3:0] alu;
    bit         imm;
    bit         reg_w;
    bit         wb;
    bit         mem;
    bit         dwe;
    bit         mdr;
    bit         psel;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass, n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int r_code(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      10'b0000000_000: return 0;  // add
      10'b0100000_000: return 1;  // sub
      10'b0000000_001: return 2;  // sll
      10'b0000000_010: return 3;  // slt
      10'b0000000_011: return 4;  // sltu
      10'b0000000_100: return 5;  // xor
      10'b0000000_101: return 6;  // srl
      10'b0100000_101: return 7;  // sra
      10'b0000000_110: return 8;  // or
      10'b0000000_111: return 9;  // and
      default:         return -1;
    endcase
  endfunction

  function automatic int i_code(input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'b000:  return 0;  // addi
      3'b010:  return 3;  // slti
      3'b011:  return 4;  // sltiu
      3'b100:  return 5;  // xori
      3'b110:  return 8;  // ori
      3'b111:  return 9;  // andi
      3'b001:  return (f7 == 7'b0000000) ? 2 : -1;
      default: return (f7 == 7'b0000000) ? 6 : (f7 == 7'b0100000) ? 7 : -1;
    endcase
  endfunction

  // di/dd: extra wait cycles before imem/dmem ack.
  function automatic exp_t model(input logic [6:0] op, input logic [9:0] fn,
                                 input bit az, input int di, input int dd,
                                 output bit legal);
    exp_t e;
    int   code;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = fn[9:3];
    f3 = fn[2:0];
    e = '{default: 0};
    code = -1;
    case (op)
      7'b0110011: begin code = r_code(f7, f3); e.exec = 1; e.reg_w = 1; e.lat = 4 + di; end
      7'b0010011: begin code = i_code(f7, f3); e.exec = 1; e.imm = 1; e.reg_w = 1; e.lat = 4 + di; end
      7'b0000011: begin
        code = 0; e.exec = 1; e.imm = 1; e.reg_w = 1; e.wb = 1;
        e.mem = 1; e.mdr = 1; e.lat = 5 + di + dd;
      end
      7'b0100011: begin
        code = 0; e.exec = 1; e.imm = 1; e.mem = 1; e.dwe = 1; e.lat = 4 + di + dd;
      end
      7'b1100011: begin
        if (f3 == 3'b000)      begin code = 1; e.psel = az;  end
        else if (f3 == 3'b001) begin code = 1; e.psel = !az; end
        e.exec = 1; e.lat = 3 + di;
      end
      default: ;
    endcase
    legal = (code >= 0);
    if (!legal) begin
      e = '{default: 0};
      e.lat = 2 + di;
    end else begin
      e.alu = 4'(code);
    end
    return e;
  endfunction

  // ---------------- memory responders ----------------
  int imem_dly, dmem_dly, icnt, dcnt;
  bit ack_force, noise_en;

  // Ack after the programmed delay while requested; random noise otherwise.
  always begin
    @(posedge clk);
    #2;
    if (imem_req === 1'b1) begin
      imem_ack = (icnt == imem_dly);
      icnt++;
    end else begin
      icnt = 0;
      imem_ack = ack_force | (noise_en & 1'($urandom_range(0, 1)));
    end
    if (dmem_req === 1'b1) begin
      dmem_ack = (dcnt == dmem_dly);
      dcnt++;
    end else begin
      dcnt = 0;
      dmem_ack = noise_en & 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  bit         sb_en;
  int         cyc;
  bit         o_exec, o_imm, o_reg, o_wb, o_mem, o_dwe, o_mdr;
  logic [3:0] o_alu;
  exp_t       m_e;

  task automatic obs_clear();
    cyc = 0; o_exec = 0; o_imm = 0; o_reg = 0; o_wb = 0;
    o_mem = 0; o_dwe = 0; o_mdr = 0; o_alu = 4'h0;
  endtask

  always @(negedge clk) begin
    if (rst_n !== 1'b1 || !sb_en) begin
      obs_clear();
    end else begin
      if (imem_req || cyc != 0) cyc++;
      if (alu_out_we) begin o_exec = 1; o_alu = alu_op; o_imm = alu_src_imm; end
      if (reg_we)     begin o_reg = 1; o_wb = wb_sel; end
      if (dmem_req)   begin o_mem = 1; o_dwe = dmem_we; end
      if (mdr_we)     o_mdr = 1;
      if (instr_retired) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_retire", 32'(instr_retired), 32'd0);
        end else begin
          m_e = sb_q.pop_front();
          chk("latency", cyc, m_e.lat);
          chk("pc_we", 32'(pc_we), 32'd1);
          chk("pc_sel", 32'(pc_sel), 32'(m_e.psel));
          chk("exec_seen", 32'(o_exec), 32'(m_e.exec));
          if (m_e.exec) begin
            chk("alu_op", 32'(o_alu), 32'(m_e.alu));
            chk("alu_src_imm", 32'(o_imm), 32'(m_e.imm));
          end
          chk("reg_we", 32'(o_reg), 32'(m_e.reg_w));
          if (m_e.reg_w) chk("wb_sel", 32'(o_wb), 32'(m_e.wb));
          chk("mem_seen", 32'(o_mem), 32'(m_e.mem));
          if (m_e.mem) chk("dmem_we", 32'(o_dwe), 32'(m_e.dwe));
          chk("mdr_we", 32'(o_mdr), 32'(m_e.mdr));
        end
        obs_clear();
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [6:0] op, input logic [9:0] fn, input bit az,
                       input int di, input int dd, input bit stop_in_mem);
    exp_t e;
    bit   legal;
    bit   done;
    e = model(op, fn, az, di, dd, legal);
    opcode = op; ins_for_ALU = fn; alu_zero = az;
    imem_dly = di; dmem_dly = dd; run = 1'b1;
    sb_q.push_back(e);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (stop_in_mem && dmem_req) run = 1'b0;
      if (instr_retired) done = 1;
    end
    if (!done) chk("retire_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic random_issue();
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit         legal;
    exp_t       tmp;
    do begin
      case ($urandom_range(0, 5))
        0:       op = 7'b0110011;
        1:       op = 7'b0010011;
        2:       op = 7'b0000011;
        3:       op = 7'b0100011;
        4:       op = 7'b1100011;
        default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'b0000000;
        2:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      tmp = model(op, {f7, f3}, 1'b0, 0, 0, legal);
    end while (TRAP_BUILD && !legal);
    issue(op, {f7, f3}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    bit done;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; run = 1'b0; opcode = '0; ins_for_ALU = '0; alu_zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_dly = 0; dmem_dly = 0;
    ack_force = 0; noise_en = 0; sb_en = 0; icnt = 0; dcnt = 0;
    obs_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(all_outs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_run0_outs", 32'(all_outs), 32'd0);
    @(posedge clk); #1;

    sb_en = 1; noise_en = 1;
    issue(7'b0110011, 10'b0100000_000, 1'b0, 0, 0, 1'b0);  // sub, zero wait
    issue(7'b0000011, 10'b0000000_010, 1'b0, 0, 3, 1'b0);  // lw, dmem ack +3
    issue(7'b1100011, 10'b0000000_001, 1'b0, 0, 0, 1'b0);  // bne, taken
    issue(7'b1100011, 10'b0000000_000, 1'b0, 0, 0, 1'b0);  // beq, not taken
    issue(7'b0010011, 10'b0100000_000, 1'b1, 1, 0, 1'b0);  // addi with f7 bits set
    repeat (150) random_issue();

    // store with run dropped during MEM: retires, then parks in IDLE
    issue(7'b0100011, 10'b0000000_010, 1'b0, 1, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_after_run_drop", 32'(all_outs), 32'd0);
    end
    @(posedge clk); #1;

`ifdef CTRL_ILLEGAL_TRAP_EN
    opcode = 7'b1111111; ins_for_ALU = '0; imem_dly = 0; run = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (trap) done = 1;
    end
    chk("trap_reached", 32'(trap), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("trap_hold", 32'(all_outs), 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("trap_cleared", 32'(all_outs), 32'd0);
    @(posedge clk); #1;
`else
    issue(7'b1111111, 10'b0000000_000, 1'b0, 1, 0, 1'b0);  // NOP retire in DECODE
    run = 1'b0;
    @(posedge clk); #1;
`endif

    // reset in the middle of a fetch handshake, then a stray imem_ack
    noise_en = 0; imem_dly = 1000; run = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (imem_req) done = 1;
    end
    chk("fetch_pending", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0; ack_force = 1;
    @(negedge clk);
    chk("reset_mid_fetch", 32'(all_outs), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_ack_ignored", 32'(all_outs), 32'd0);
    end
    ack_force = 0;

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the lab RV32I-subset datapath. Consumes the decoder's opcode and {funct7,funct3} fields and sequences fetch/decode/execute/memory/writeback. Drives register, PC, ALU and memory-handshake enables for a single shared memory-port pair. Sits between the decoder and the datapath registers/ALU/regfile.

Parameters:
ALU_OP_W, 4, width of alu_op output
IMEM_TIMEOUT, 0, reserved; must be 0 (no timeout); any other value is a synthesis-time error

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  enable instruction sequencing
opcode  in  7  decoder opcode field
ins_for_ALU  in  10  decoder {funct7,funct3}
alu_zero  in  1  ALU result==0 flag (valid in EXEC)
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
ir_we  out  1  instruction register load
ab_we  out  1  operand A/B register load
alu_out_we  out  1  ALU output register load
mdr_we  out  1  memory data register load
reg_we  out  1  regfile write
wb_sel  out  1  0=ALU result, 1=MDR
alu_src_imm  out  1  ALU B operand: 0=rs2, 1=immediate
alu_op  out  ALU_OP_W  ALU operation
pc_we  out  1  PC load
pc_sel  out  1  0=PC+4, 1=branch target
instr_retired  out  1  one-cycle pulse per completed instruction
trap  out  1  illegal-instruction halt indicator

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-low (clk, rst_n).
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset -> IDLE. All outputs are combinational from state/class/acks; IDLE drives every output 0, so all outputs read 0 after a reset edge.
- IDLE: run=1 -> FETCH.
- FETCH: imem_req=1. imem_ack=1 -> ir_we=1 in that cycle, next DECODE. Otherwise stay (unbounded wait).
- DECODE: ab_we=1. Latch class from opcode: R=0110011, IALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011 with funct3 000 (BEQ) or 001 (BNE). Anything else is illegal (see Optional Feature). Next EXEC.
- EXEC: alu_out_we=1. alu_op from alu_op_decode. alu_src_imm=1 for IALU/LOAD/STORE. LOAD/STORE force ADD.
  - BRANCH: forces SUB. pc_we=1, pc_sel = (BEQ & alu_zero) | (BNE & ~alu_zero), instr_retired=1, next FETCH/IDLE.
  - LOAD/STORE -> MEM. R/IALU -> WB.
- MEM: dmem_req=1, dmem_we=STORE. On dmem_ack:
  - LOAD: mdr_we=1 -> WB.
  - STORE: pc_we=1, pc_sel=0, instr_retired=1 -> FETCH/IDLE.
- WB: reg_we=1, wb_sel=LOAD, pc_we=1, pc_sel=0, instr_retired=1. Next FETCH/IDLE.
- "FETCH/IDLE": next is FETCH if run=1, else IDLE. run is sampled only at instruction boundaries; deasserting mid-instruction lets the instruction complete.
- alu_op encoding: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9.
  - R-type: funct7=0100000 selects SUB (f3=000) or SRA (f3=101); funct7=0000000 gives the base op; any other funct7 is illegal.
  - IALU: funct7 is checked only for f3=001/101. f3=000 is ADDI, never SUB.
  - alu_op=0 outside EXEC.
- Zero-wait latency: BRANCH 3 cycles, R/IALU 4, STORE 4, LOAD 5.
- Reset asserted in any state, including mid-handshake -> IDLE on that edge. Request drops with no completion pulse.
- Acks arriving outside their request state are ignored.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal instruction in DECODE goes to TRAP. TRAP holds trap=1, all other outputs 0, and never retires; only rst_n exits it.
- Undefined: illegal instruction is a NOP. DECODE asserts pc_we=1, pc_sel=0, instr_retired=1, then goes FETCH/IDLE. trap is tied 0.

Decomposition:
- ctrl_pkg:
  - state enum
  - opcode constants (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH)
  - instruction-class enum
  - ALU_* op codes
  - PC_PLUS4/PC_BRANCH and WB_ALU/WB_MDR constants
- Sub-module alu_op_decode: combinational {class, ins_for_ALU} -> {alu_op, illegal}. Shared with future pipelined control.

Test Plan:
- Reset, run=1, opcode=0110011, ins_for_ALU=0100000_000, acks tied 1 -> FETCH,DECODE,EXEC(alu_op=1),WB(reg_we=1,wb_sel=0); instr_retired at cycle 4.
- LOAD, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, mdr_we with ack, WB wb_sel=1; 8 cycles total.
- BNE with alu_zero=0 -> EXEC pc_we=1, pc_sel=1, alu_op=1. BEQ with alu_zero=0 -> pc_sel=0. No reg_we in either.
- STORE, then run=0 during MEM -> dmem_we=1, retires, enters IDLE; imem_req stays 0.
- opcode=1111111:
  - with CTRL_ILLEGAL_TRAP_EN -> trap=1 persists; rst_n=0 for one edge clears it.
  - without -> NOP retire in DECODE.
- rst_n=0 mid-FETCH with imem_req=1 -> next cycle all outputs 0, state IDLE. Late imem_ack is ignored.
